// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel edge path: pixel width, window-generator
// phase encoding and the raster counter width helper.
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        FILL,
        PRIME,
        EMIT
    } win_phase_t;

    // Width of the raster counters: enough bits to hold max(width, height) - 1.
    function automatic int cnt_width(input int width, input int height);
        int m;
        m = (width > height) ? width : height;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of pixel storage: asynchronous read, synchronous write.
// A read and a write to the same address in one cycle return the old data.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Store the incoming pixel at the current column.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Sobel window generator: buffers two image lines and presents a registered
// 3x3 neighbourhood with a one-cycle done_o strobe for every interior pixel.
// Optional feature macro: SOBEL_WIN_FRAME_CNT_EN adds a 16-bit frame counter
// output frame_cnt_o.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_i,
    input  logic             valid_i,
    output logic [PIX_W-1:0] d0_o,
    output logic [PIX_W-1:0] d1_o,
    output logic [PIX_W-1:0] d2_o,
    output logic [PIX_W-1:0] d3_o,
    output logic [PIX_W-1:0] d4_o,
    output logic [PIX_W-1:0] d5_o,
    output logic [PIX_W-1:0] d6_o,
    output logic [PIX_W-1:0] d7_o,
    output logic [PIX_W-1:0] d8_o,
    output logic             done_o,
`ifdef SOBEL_WIN_FRAME_CNT_EN
    output logic [15:0]      frame_cnt_o,
    output logic             frame_done_o
`else
    output logic             frame_done_o
`endif
);

    localparam int CW = cnt_width(IMG_WIDTH, IMG_HEIGHT);

    logic [CW-1:0]    col;
    logic [CW-1:0]    row;
    logic             accept;
    logic             col_last;
    logic             row_last;
    win_phase_t       phase;
    win_phase_t       phase_nxt;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    // Only the two older window columns are stored; the newest column comes
    // straight from the line-buffer reads and pixel_i on the accepting cycle.
    logic [PIX_W-1:0] top_a, top_b;
    logic [PIX_W-1:0] mid_a, mid_b;
    logic [PIX_W-1:0] bot_a, bot_b;

    assign accept   = valid_i && !rst;
    assign col_last = (col == CW'(IMG_WIDTH - 1));
    assign row_last = (row == CW'(IMG_HEIGHT - 1));

    sobel_line_buf #(
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (pixel_i),
        .rdata (lb0_rd)
    );

    sobel_line_buf #(
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Phase state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= FILL;
        end else begin
            phase <= phase_nxt;
        end
    end

    // Phase transitions, evaluated on the position of the pixel being accepted.
    always_comb begin
        phase_nxt = phase;
        if (accept) begin
            case (phase)
                FILL:    if (col_last && row == CW'(1)) phase_nxt = PRIME;
                PRIME:   if (col == CW'(1))              phase_nxt = EMIT;
                EMIT:    if (col_last)                   phase_nxt = row_last ? FILL : PRIME;
                default: phase_nxt = FILL;
            endcase
        end
    end

    // Shift the window columns and capture the full window on emitting pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_a <= '0; top_b <= '0;
            mid_a <= '0; mid_b <= '0;
            bot_a <= '0; bot_b <= '0;
            d0_o  <= '0; d1_o  <= '0; d2_o <= '0;
            d3_o  <= '0; d4_o  <= '0; d5_o <= '0;
            d6_o  <= '0; d7_o  <= '0; d8_o <= '0;
        end else if (accept) begin
            top_a <= top_b; top_b <= lb1_rd;
            mid_a <= mid_b; mid_b <= lb0_rd;
            bot_a <= bot_b; bot_b <= pixel_i;
            if (phase == EMIT) begin
                d0_o <= top_a; d1_o <= top_b; d2_o <= lb1_rd;
                d3_o <= mid_a; d4_o <= mid_b; d5_o <= lb0_rd;
                d6_o <= bot_a; d7_o <= bot_b; d8_o <= pixel_i;
            end
        end
    end

    // Window-valid and end-of-frame strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            done_o       <= accept && (phase == EMIT);
            frame_done_o <= accept && col_last && row_last;
        end
    end

`ifdef SOBEL_WIN_FRAME_CNT_EN
    // Completed-frame counter, stepping in the same cycle as frame_done_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_o <= '0;
        end else if (accept && col_last && row_last) begin
            frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end
`endif

endmodule
